restoring_divider_ctrl: RTL and testbench
=========================================

Name: restoring_divider_ctrl

Overview:
- Sequential unsigned restoring divider controller: quotient and remainder of dividend/divisor.
- Wraps the team's existing WIDTH-bit ripple subtractor as its datapath. This block drives the subtractor's A/B/Cin and consumes its difference and borrow-out, one trial subtraction per clock.
- Sits between the lab ALU's operand registers and its result mux. Start/done handshake toward the ALU sequencer.

Parameters:
- WIDTH, 4, operand/quotient/remainder width; must equal the attached subtractor's width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  unsigned dividend, sampled with start.
- divisor  in  WIDTH  unsigned divisor, sampled with start.
- busy  out  1  high in ITER state.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  registered quotient, held until next accepted start.
- remainder  out  WIDTH  registered remainder, held until next accepted start.
- div_by_zero  out  1  registered; set when divisor was 0, held like quotient.
- sub_a  out  WIDTH  subtractor minuend.
- sub_b  out  WIDTH  subtractor subtrahend.
- sub_cin  out  1  subtractor borrow-in; constant 0.
- sub_res  in  WIDTH  subtractor difference (A-B mod 2^WIDTH).
- sub_borrow  in  1  subtractor borrow-out; 1 means A<B.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal R, Q, D and count are all 0.
- States: IDLE, ITER, DONE.
- IDLE + start=1, divisor!=0: load R=0, Q=dividend, D=divisor, count=WIDTH-1, div_by_zero=0; go to ITER.
- IDLE + start=1, divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1; go to DONE (latency 1 edge).
- ITER, each cycle:
  - Shifted partial remainder S={R[WIDTH-2:0],Q[WIDTH-1]}, shifted-out bit m=R[WIDTH-1].
  - Drive sub_a=S, sub_b=D, sub_cin=0.
  - accept = m | ~sub_borrow.
  - On the edge: R <= accept ? sub_res : S; Q <= {Q[WIDTH-2:0], accept}.
  - count==0 → copy Q/R to quotient/remainder and go to DONE; otherwise count decrements.
  - The m term guards against the shifted remainder exceeding WIDTH bits. It is unreachable for WIDTH-bit dividends but is required.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- Latency: done is high in the cycle after the WIDTH-th edge following the start-sampling edge, i.e. WIDTH cycles (4 at default). Divide-by-zero latency is 1 cycle.
- start while busy (ITER) or in DONE: ignored, no effect on the operation in flight.
- dividend/divisor changes after acceptance: no effect.
- sub_a/sub_b in IDLE/DONE: drive 0.
- Reset mid-operation: immediate return to reset values; no done pulse; partial results discarded.
- Outputs quotient/remainder/div_by_zero change only on the DONE-entry edge or on reset.

Optional Feature:
- Macro DIV_RESULT_FLAGS_EN.
- Defined: adds outputs q_zero (1 bit) and exact (1 bit), both registered on the same edge as quotient. q_zero = (quotient==0); exact = (remainder==0). Both are 0 on reset and held with the results. For divide-by-zero, q_zero=0 and exact=0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- rst high 2 cycles, release, then dividend=13, divisor=4, start 1 cycle → busy for 4 cycles; done 1-cycle pulse at latency 4; quotient=3, remainder=1, div_by_zero=0.
- 15/1 → quotient=15, remainder=0; with DIV_RESULT_FLAGS_EN: q_zero=0, exact=1.
- 7/0 → done next cycle (latency 1); quotient=4'hF, remainder=7, div_by_zero=1, busy never high.
- 3/9 → quotient=0, remainder=3; with the macro: q_zero=1, exact=0. Then 9/3 issued → previous results held until done; new quotient=3, remainder=0.
- Start 12/5; pulse start with 15/2 during cycle 2 of ITER → ignored; result quotient=2, remainder=2 at latency 4, only one done pulse.
- Start 14/3; assert rst during ITER cycle 2 → all outputs 0 immediately, no done. After release, 14/3 → quotient=4, remainder=2.

Source files
------------

// File: rtl/restoring_divider_ctrl_if.sv
// Bundle of signals between the ALU sequencer and the restoring divider
// controller.
//
// Parameter: WIDTH - operand / quotient / remainder width.
//
// Signals:
//   start             sequencer -> divider  request, sampled only while idle
//   dividend, divisor sequencer -> divider  operands, sampled with start
//   busy              divider -> sequencer  an iteration is in progress
//   done              divider -> sequencer  one-cycle pulse, results valid
//   quotient, remainder, div_by_zero        registered results, held
//   q_zero, exact     result flags, present only with DIV_RESULT_FLAGS_EN
//   state_dbg         divider FSM state, for checkers and debug
//
// Handshake: start is a request without a ready. It is taken only in the
// idle state, and ignored while busy or during the done cycle. Completion is
// signalled by exactly one done pulse per accepted start, and results are
// valid from that cycle until the next operation completes. The sequencer
// must not rely on a start being taken unless busy or done follows it.
//
// Optional feature macro: DIV_RESULT_FLAGS_EN (adds q_zero and exact).
interface restoring_divider_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef DIV_RESULT_FLAGS_EN
  logic             q_zero;
  logic             exact;
`endif
  logic [1:0]       state_dbg;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero,
`ifdef DIV_RESULT_FLAGS_EN
    input  q_zero, exact,
`endif
    input  state_dbg
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero,
`ifdef DIV_RESULT_FLAGS_EN
    output q_zero, exact,
`endif
    output state_dbg
  );
endinterface

// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider controller. Computes
// dividend / divisor one quotient bit per clock, using an external WIDTH-bit
// ripple subtractor for the trial subtraction.
//
// Parameter: WIDTH - operand width, must match the attached subtractor
//            (WIDTH >= 2).
//
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   bus         restoring_divider_ctrl_if.slave: start/dividend/divisor in,
//               busy/done/quotient/remainder/div_by_zero out, state_dbg out
//   sub_a       subtractor minuend (0 outside the iteration state)
//   sub_b       subtractor subtrahend (0 outside the iteration state)
//   sub_cin     subtractor borrow-in, tied 0
//   sub_res     subtractor difference, sub_a - sub_b mod 2^WIDTH
//   sub_borrow  subtractor borrow-out, 1 when sub_a < sub_b
//
// Optional feature macro: DIV_RESULT_FLAGS_EN adds q_zero / exact on the bus.
module restoring_divider_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  restoring_divider_ctrl_if.slave bus,
  output logic [WIDTH-1:0]       sub_a,
  output logic [WIDTH-1:0]       sub_b,
  output logic                   sub_cin,
  input  logic [WIDTH-1:0]       sub_res,
  input  logic                   sub_borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient in
  logic [WIDTH-1:0] d_q, d_d;        // captured divisor
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
`ifdef DIV_RESULT_FLAGS_EN
  logic             qz_q, qz_d;
  logic             ex_q, ex_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic             msb_out;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_RESULT_FLAGS_EN
      qz_q    <= 1'b0;
      ex_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef DIV_RESULT_FLAGS_EN
      qz_q    <= qz_d;
      ex_q    <= ex_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_RESULT_FLAGS_EN
    qz_d    = qz_q;
    ex_d    = ex_q;
`endif
    sub_a   = '0;
    sub_b   = '0;
    sub_cin = 1'b0;

    // Shift the next dividend bit into the partial remainder. The bit
    // shifted out of R means the shifted value is >= 2^WIDTH and therefore
    // certainly >= D, whatever the subtractor's borrow says.
    shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    msb_out = r_q[WIDTH-1];
    accept  = msb_out | ~sub_borrow;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            r_d     = '0;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            count_d = CW'(WIDTH - 1);
            dz_d    = 1'b0;
            state_d = ITER;
          end else begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
`ifdef DIV_RESULT_FLAGS_EN
            qz_d    = 1'b0;
            ex_d    = 1'b0;
`endif
            state_d = DONE;
          end
        end
      end
      ITER: begin
        sub_a = shifted;
        sub_b = d_q;
        r_d   = accept ? sub_res : shifted;
        q_d   = {q_q[WIDTH-2:0], accept};
        if (count_q == '0) begin
          // Publish the values produced by this last step, not the old ones.
          quot_d  = q_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
`ifdef DIV_RESULT_FLAGS_EN
          qz_d    = (q_d == '0);
          ex_d    = (r_d == '0);
`endif
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q == ITER);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
`ifdef DIV_RESULT_FLAGS_EN
  assign bus.q_zero      = qz_q;
  assign bus.exact       = ex_q;
`endif
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Testbench for restoring_divider_ctrl: directed divisions with literal
// expected results, plus a cycle-level reference model built from integer
// / and % that is compared against the outputs on every falling edge.
module tb_restoring_divider_ctrl;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  restoring_divider_ctrl_if #(.WIDTH(W)) bus ();

  logic [W-1:0] sub_a, sub_b, sub_res;
  logic         sub_cin, sub_borrow;

  // Behavioural stand-in for the team's ripple subtractor.
  logic [W:0] sub_wide;
  assign sub_wide   = {1'b0, sub_a} - {1'b0, sub_b};
  assign sub_res    = sub_wide[W-1:0];
  assign sub_borrow = sub_wide[W];

  restoring_divider_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_cin    (sub_cin),
    .sub_res    (sub_res),
    .sub_borrow (sub_borrow)
  );

  logic         start;
  logic [W-1:0] dividend, divisor;
  assign bus.start    = start;
  assign bus.dividend = dividend;
  assign bus.divisor  = divisor;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results come from integer division; timing is "done WIDTH edges after
  // the accepting edge" for normal operands and the next edge for divisor 0.
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_q, m_r, m_div, p_q, p_r;
  int           m_left;
`ifdef DIV_RESULT_FLAGS_EN
  logic         m_qz, m_ex;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_div <= '0; p_q <= '0; p_r <= '0;
      m_left <= 0;
`ifdef DIV_RESULT_FLAGS_EN
      m_qz <= 1'b0; m_ex <= 1'b0;
`endif
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= p_q; m_r <= p_r; m_dz <= 1'b0;
`ifdef DIV_RESULT_FLAGS_EN
          m_qz <= (p_q == '0); m_ex <= (p_r == '0);
`endif
        end
      end else if (!m_done && start) begin
        if (divisor == '0) begin
          m_done <= 1'b1; m_q <= '1; m_r <= dividend; m_dz <= 1'b1;
`ifdef DIV_RESULT_FLAGS_EN
          m_qz <= 1'b0; m_ex <= 1'b0;
`endif
        end else begin
          m_busy <= 1'b1; m_left <= W; m_dz <= 1'b0;
          p_q <= dividend / divisor; p_r <= dividend % divisor;
          m_div <= divisor;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("quotient", bus.quotient, m_q);
      check("remainder", bus.remainder, m_r);
      check("div_by_zero", bus.div_by_zero, m_dz);
      check("sub_cin", sub_cin, 1'b0);
      if (m_busy) begin
        check("sub_b_busy", sub_b, m_div);
      end else begin
        check("sub_a_idle", sub_a, '0);
        check("sub_b_idle", sub_b, '0);
      end
`ifdef DIV_RESULT_FLAGS_EN
      check("q_zero", bus.q_zero, m_qz);
      check("exact", bus.exact, m_ex);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // exp_cyc: falling edges from the launch of start until done is seen
  // (WIDTH+1 for a normal divide, 1 for divide-by-zero).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_cyc,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input string tag);
    int cyc, busy_cyc;
    bit seen;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    cyc = 0; busy_cyc = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      dividend = ~a;   // operands must be ignored after acceptance
      divisor  = b + 4'd1;
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_busy_cycles"}, busy_cyc, (b != '0) ? W : 0);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_dz"}, bus.div_by_zero, edz);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  int dones;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; dividend = '0; divisor = '0;
    rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", bus.quotient, '0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;

    do_op(4'd13, 4'd4, W + 1, 4'd3, 4'd1, 1'b0, "13/4");
    do_op(4'd15, 4'd1, W + 1, 4'd15, 4'd0, 1'b0, "15/1");
`ifdef DIV_RESULT_FLAGS_EN
    check("15/1_q_zero", bus.q_zero, 1'b0);
    check("15/1_exact", bus.exact, 1'b1);
`endif
    do_op(4'd7, 4'd0, 1, 4'hF, 4'd7, 1'b1, "7/0");
    do_op(4'd3, 4'd9, W + 1, 4'd0, 4'd3, 1'b0, "3/9");
`ifdef DIV_RESULT_FLAGS_EN
    check("3/9_q_zero", bus.q_zero, 1'b1);
    check("3/9_exact", bus.exact, 1'b0);
`endif
    // Previous 3/9 results must stay visible until the 9/3 done.
    @(negedge clk);
    dividend = 4'd9; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_quotient", bus.quotient, 4'd0);
    check("hold_remainder", bus.remainder, 4'd3);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check("9/3_quotient", bus.quotient, 4'd3);
        check("9/3_remainder", bus.remainder, 4'd0);
      end
    end
    check("9/3_dones", dones, 1);

    // Start pulse during the second ITER cycle must be ignored.
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd15; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check("12/5_quotient", bus.quotient, 4'd2);
        check("12/5_remainder", bus.remainder, 4'd2);
      end
    end
    check("12/5_dones", dones, 1);

    // Reset in the middle of an operation.
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_quotient", bus.quotient, 4'd0);
    check("midrst_remainder", bus.remainder, 4'd0);
    check("midrst_dz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    do_op(4'd14, 4'd3, W + 1, 4'd4, 4'd2, 1'b0, "14/3");

    // Boundaries.
    do_op(4'd0, 4'd5, W + 1, 4'd0, 4'd0, 1'b0, "0/5");
    do_op(4'd15, 4'd15, W + 1, 4'd1, 4'd0, 1'b0, "15/15");
    do_op(4'd8, 4'd15, W + 1, 4'd0, 4'd8, 1'b0, "8/15");
    do_op(4'd0, 4'd0, 1, 4'hF, 4'd0, 1'b1, "0/0");
    do_op(4'd15, 4'd2, W + 1, 4'd7, 4'd1, 1'b0, "15/2");

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
